// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

  // funct3 load/store length encodings
  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DREAD  = 2'd1;
  localparam logic [1:0] ST_DWRITE = 2'd2;
  localparam logic [1:0] ST_IREAD  = 2'd3;

  // First byte of the 8-byte IO window
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  // Request fields latched at acceptance; the address lives in the bus address register
  typedef struct packed {
    logic [2:0]  len;
    logic [31:0] value;
  } mem_req_t;

  // Number of bus bytes for a funct3 length: 00 -> 1, 01 -> 2, 1x -> 4
  function automatic logic [2:0] byte_cnt(input logic [2:0] len);
    case (len[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Combinational sign/zero extender for little-endian load data.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  len,
  output logic [31:0] result
);

  // Extend from bit 8N-1; unsigned forms zero-fill, words pass through
  always_comb begin
    result = raw;
    case (len)
      LEN_B:   result = {{24{raw[7]}}, raw[7:0]};
      LEN_BU:  result = {24'h0, raw[7:0]};
      LEN_H:   result = {{16{raw[15]}}, raw[15:0]};
      LEN_HU:  result = {16'h0, raw[15:0]};
      LEN_W:   result = raw;
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB data and instruction fetch
// onto the 8-bit RAM/IO bus, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        lsb_valid,
  input  logic        lsb_wr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_value,
  output logic        lsb_ready,
  output logic [31:0] lsb_result,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data
);

  logic [1:0]  state_q;
  mem_req_t    req_q;
  logic [2:0]  cnt_q;      // current cycle index k within the transaction
  logic [31:0] asm_q;      // little-endian assembly of read bytes
  logic [31:0] asm_nxt;
  logic [31:0] ext_res;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        lsb_ready_q;
  logic        if_ready_q;
  logic        kill_q;     // flush seen during a write: finish bytes, drop the pulse
  logic [2:0]  n_bytes;
  logic        io_stall;
  logic [1:0]  cap_idx;
  logic [1:0]  nxt_idx;

  assign n_bytes  = (state_q == ST_IREAD) ? 3'd4 : byte_cnt(req_q.len);
  // Wrap-safe window test: IO_BASE..IO_BASE+7
  assign io_stall = io_buffer_full && (state_q == ST_DWRITE) &&
                    ((mem_a_q - IO_BASE) < 32'd8);
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign nxt_idx  = cnt_q[1:0] + 2'd1;

  // Byte presented in cycle k-1 arrives in cycle k; fold it into the assembly
  always_comb begin
    asm_nxt = asm_q;
    if (cnt_q != 3'd0) asm_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  mem_ext u_ext (
    .raw    (asm_nxt),
    .len    (req_q.len),
    .result (ext_res)
  );

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q && rdy_in && !io_stall;
  assign lsb_ready = lsb_ready_q && !rob_clear;
  assign if_ready  = if_ready_q && !rob_clear;

  // Arbiter + byte sequencer; ready pulses last exactly one cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= 3'd0;
      asm_q       <= 32'h0;
      mem_a_q     <= 32'h0;
      mem_dout_q  <= 8'h0;
      mem_wr_q    <= 1'b0;
      lsb_ready_q <= 1'b0;
      lsb_result  <= 32'h0;
      if_ready_q  <= 1'b0;
      if_data     <= 32'h0;
      kill_q      <= 1'b0;
    end else if (rdy_in) begin
      lsb_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A requester is not re-accepted while its own ready pulse is up
          if (!rob_clear) begin
            if (lsb_valid && !lsb_ready_q) begin
              req_q      <= '{len: lsb_len, value: lsb_value};
              state_q    <= lsb_wr ? ST_DWRITE : ST_DREAD;
              mem_a_q    <= lsb_addr;
              mem_wr_q   <= lsb_wr;
              mem_dout_q <= lsb_wr ? lsb_value[7:0] : 8'h0;
              cnt_q      <= 3'd0;
              asm_q      <= 32'h0;
              kill_q     <= 1'b0;
            end else if (if_valid && !if_ready_q) begin
              req_q      <= '{len: LEN_W, value: 32'h0};
              state_q    <= ST_IREAD;
              mem_a_q    <= if_addr;
              mem_wr_q   <= 1'b0;
              mem_dout_q <= 8'h0;
              cnt_q      <= 3'd0;
              asm_q      <= 32'h0;
              kill_q     <= 1'b0;
            end
          end
        end
        ST_DREAD, ST_IREAD: begin
          if (rob_clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end else begin
            asm_q <= asm_nxt;
            if (cnt_q == n_bytes) begin
              state_q <= ST_IDLE;
              cnt_q   <= 3'd0;
              if (state_q == ST_IREAD) begin
                if_ready_q <= 1'b1;
                if_data    <= asm_nxt;
              end else begin
                lsb_ready_q <= 1'b1;
                lsb_result  <= ext_res;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q + 3'd1 < n_bytes) mem_a_q <= mem_a_q + 32'd1;
            end
          end
        end
        ST_DWRITE: begin
          if (rob_clear) kill_q <= 1'b1;
          if (!io_stall) begin
            if (cnt_q + 3'd1 == n_bytes) begin
              state_q     <= ST_IDLE;
              mem_wr_q    <= 1'b0;
              cnt_q       <= 3'd0;
              lsb_ready_q <= !(kill_q || rob_clear);
              lsb_result  <= 32'h0;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= req_q.value[{nxt_idx, 3'b000} +: 8];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the core and the 8-bit unified RAM/IO bus.
- Serves two clients:
  - the load/store buffer's data port (load or store, 1/2/4 bytes);
  - the instruction-fetch port (aligned 4-byte word reads).
- Arbitrates between the two clients and sequences one byte per cycle.
- Assembles little-endian results with sign/zero extension and returns a one-cycle ready pulse to the requester.

Parameters:
- IO_BASE, 32'h00030000: first address of the IO window; IO occupies IO_BASE..IO_BASE+7.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes the block
- rob_clear  in  1  pipeline flush
- io_buffer_full  in  1  IO write buffer full
- mem_din  in  8  RAM read byte; valid the cycle after its address is presented
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- lsb_valid  in  1  data request level
- lsb_wr  in  1  1 = store
- lsb_len  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsb_addr  in  32  byte address
- lsb_value  in  32  store data (low bytes used)
- lsb_ready  out  1  one-cycle done pulse
- lsb_result  out  32  extended load data; valid while lsb_ready is high
- if_valid  in  1  fetch request level
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle done pulse
- if_data  out  32  fetched word; valid while if_ready is high

Behaviour:
- Reset (rst_in=1 at an edge):
  - state IDLE;
  - mem_a=0, mem_dout=0, mem_wr=0;
  - lsb_ready=0, lsb_result=0, if_ready=0, if_data=0;
  - byte counter and assembly register = 0.
  - Reset mid-transaction aborts it; no ready pulse is produced.
- rdy_in=0: all registers hold. mem_wr is combinationally forced to 0.
- States: IDLE, DREAD, DWRITE, IREAD.
- IDLE acceptance, at the accept edge (edge 0):
  - lsb_valid takes priority over if_valid.
  - A request is ignored in the cycle its own ready pulse is high; it is accepted from the next cycle.
  - Address, length, value and wr are latched at acceptance. Inputs are don't-care afterwards.
- Byte count N: len[1:0] 00→1, 01→2, 1x→4. Fetch is always 4.
- Cycle numbering: cycle k is the interval after edge k.
- Read (DREAD / IREAD):
  - mem_a = A+k and mem_wr = 0 during cycles 0..N-1.
  - mem_din in cycle k+1 is byte k, captured into bits [8k+7:8k].
  - Ready and result are registered and high in cycle N+1 only. LW/fetch ready in cycle 5; LB ready in cycle 2.
  - State returns to IDLE at edge N+1.
- Extension: len[2]=0 sign-extends from bit 8N-1; len[2]=1 zero-extends; word loads are passed through unchanged.
- Write (DWRITE):
  - mem_wr=1, mem_a=A+k, mem_dout=value[8k+7:8k] during cycles 0..N-1.
  - lsb_ready is high in cycle N with mem_wr=0. lsb_result=0 for stores.
- IO stall: while io_buffer_full=1 and the current write address is within the IO window:
  - mem_wr is driven 0 and the byte counter holds;
  - subsequent cycle numbers shift by the stall length.
- rob_clear:
  - DREAD or IREAD in progress: abort to IDLE at that edge, no ready pulse.
  - DWRITE in progress: remaining bytes complete, but lsb_ready is suppressed.
  - A request present in IDLE during rob_clear is not accepted.
  - A ready pulse already registered for the current cycle is forced low while rob_clear is high.
- Address arithmetic is 32-bit wrap-around. Unaligned accesses are permitted and are simply byte-sequential.
- Only one transaction is outstanding at a time. A pending, unserved requester holds its valid level.

Decomposition:
- Shared config include:
  - funct3 length encodings (LEN_B/H/W/BU/HU);
  - state encodings;
  - IO_BASE default.
- One natural sub-module: mem_ext, a combinational sign/zero-extender taking (raw 32-bit, len) to the extended result, reusable by any future cache.
- The FSM and arbiter stay in mem_ctrl.

Test Plan:
- LW at 0x100 holding bytes 11,22,33,44: mem_a=0x100..0x103 in cycles 0..3; lsb_ready in cycle 5 with lsb_result=0x44332211.
- LB at 0x200 holding 0x80 → lsb_result=0xFFFFFF80 in cycle 2. LBU → 0x00000080. LH over bytes 0x34,0xF2 → 0xFFFFF234.
- SH value 0xDEADBEEF at 0x300: mem_wr=1 with (0x300,EF) in cycle 0 and (0x301,BE) in cycle 1; lsb_ready and mem_wr=0 in cycle 2.
- lsb_valid and if_valid asserted together: data served first, then fetch accepted the cycle after lsb_ready, if_ready 5 cycles after that; both results correct.
- SB to 0x30000 with io_buffer_full high for 3 cycles: mem_wr held 0, then a single write of the byte; lsb_ready 3 cycles late.
- rob_clear in cycle 2 of an LW: no lsb_ready, IDLE next cycle. rst_in mid-write: all outputs 0 next cycle, no further mem_wr.
